// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM encoding and the
// flag bundle handed to the control unit.
package alu_pkg;

    // Operation codes on func
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOT = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Controller states
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MUL_RUN = 2'd1;
    localparam logic [1:0] S_DIV_RUN = 2'd2;
    localparam logic [1:0] S_FINISH  = 2'd3;

    // Flag bundle, MSB first as seen by the control unit
    typedef struct packed {
        logic overflow;
        logic div_zero;
        logic equals;
        logic above;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine for unsigned shift-add multiply and restoring divide.
// Ports: load_i loads a_i into the accumulator low half, b_i as the
// multiplicand/divisor, and arms the counter with WIDTH; step_i runs one
// iteration (divide when is_div_i, else multiply). acc_o is the 2*WIDTH
// accumulator (MUL: product; DIV: {remainder, quotient}); cnt_o is the
// remaining iteration count.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 step_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic [CNT_W-1:0]     cnt_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     mul_sum_c;
    logic [WIDTH:0]     rem_sh_c;

    // One iteration per step; the counter stops at zero instead of wrapping
    always_comb begin
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        // MUL: conditionally add multiplicand into the high half, carry kept
        mul_sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        // DIV: partial remainder after shifting in the next dividend bit
        rem_sh_c  = acc_q[2*WIDTH-1:WIDTH-1];
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            opb_d = b_i;
            cnt_d = CNT_W'(WIDTH);
        end else if (step_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (is_div_i) begin
                if (rem_sh_c >= {1'b0, opb_q}) begin
                    acc_d = {WIDTH'(rem_sh_c - {1'b0, opb_q}), acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {rem_sh_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
        end
    end

    // Stepping an exhausted counter means a (WIDTH+1)-th iteration
    always_ff @(posedge clk) begin
        if (rst_n && step_i) begin
            assert (cnt_q != '0);
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/arith ops,
// iterative signed MUL/DIV with remainder and divide-by-zero flag.
// Ports: start/func/op1/op2 request (accepted in IDLE only); busy high while
// MUL/DIV iterate; done pulses one cycle when result/remainder/flags update;
// overflow, div_zero, equals, above, zero flags hold until the next done.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             overflow,
    output logic             div_zero,
    output logic             equals,
    output logic             above,
    output logic             zero
);

    logic [1:0]         state_q, state_d;
    logic [2:0]         func_q, func_d;
    logic [WIDTH-1:0]   op1_q, op1_d;
    logic               neg_q, neg_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    alu_flags_t         flags_q, flags_d;

    logic               load_c, step_c;
    logic [WIDTH-1:0]   sum_c, diff_c, a_mag_c, b_mag_c;
    logic [2*WIDTH-1:0] acc_c, prod_c;
    logic [CNT_W-1:0]   cnt_c;
    logic [WIDTH-1:0]   quot_c, rem_s_c;
    logic               mul_ovf_c, div_ovf_c;

    alu_muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load_c),
        .step_i   (step_c),
        .is_div_i (state_q == S_DIV_RUN),
        .a_i      (a_mag_c),
        .b_i      (b_mag_c),
        .acc_o    (acc_c),
        .cnt_o    (cnt_c)
    );

    // Datapath: single-cycle arithmetic, magnitudes, and MUL/DIV sign fix-up
    always_comb begin
        sum_c   = op1 + op2;
        diff_c  = op1 - op2;
        a_mag_c = op1[WIDTH-1] ? ('0 - op1) : op1;
        b_mag_c = op2[WIDTH-1] ? ('0 - op2) : op2;
        prod_c  = neg_q ? ('0 - acc_c) : acc_c;
        // Product fits iff its top WIDTH+1 bits are a pure sign extension
        mul_ovf_c = !((&prod_c[2*WIDTH-1:WIDTH-1]) || (~|prod_c[2*WIDTH-1:WIDTH-1]));
        quot_c  = neg_q ? ('0 - acc_c[WIDTH-1:0]) : acc_c[WIDTH-1:0];
        rem_s_c = op1_q[WIDTH-1] ? ('0 - acc_c[2*WIDTH-1:WIDTH]) : acc_c[2*WIDTH-1:WIDTH];
        // A positive quotient of magnitude 2^(WIDTH-1) only arises from MIN / -1
        div_ovf_c = !neg_q && acc_c[WIDTH-1];
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        func_d   = func_q;
        op1_d    = op1_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        rem_d    = rem_q;
        flags_d  = flags_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    func_d = func;
                    op1_d  = op1;
                    neg_d  = op1[WIDTH-1] ^ op2[WIDTH-1];
                    dz_d   = 1'b0;
                    case (func)
                        ALU_MUL: begin
                            load_c  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = S_MUL_RUN;
                        end
                        ALU_DIV: begin
                            if (op2 == '0) begin
                                dz_d    = 1'b1;
                                state_d = S_FINISH;
                            end else begin
                                load_c  = 1'b1;
                                busy_d  = 1'b1;
                                state_d = S_DIV_RUN;
                            end
                        end
                        default: begin
                            done_d  = 1'b1;
                            rem_d   = '0;
                            flags_d = '0;
                            case (func)
                                ALU_ADD: begin
                                    result_d = sum_c;
                                    flags_d.overflow = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                                                       (sum_c[WIDTH-1] != op1[WIDTH-1]);
                                end
                                ALU_SUB: begin
                                    result_d = diff_c;
                                    flags_d.overflow = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                                                       (diff_c[WIDTH-1] != op1[WIDTH-1]);
                                    flags_d.equals = (op1 == op2);
                                    flags_d.above  = ($signed(op1) > $signed(op2));
                                end
                                ALU_AND: result_d = op1 & op2;
                                ALU_OR:  result_d = op1 | op2;
                                ALU_NOT: result_d = ~op1;
                                default: result_d = WIDTH'($signed(op1) < $signed(op2));
                            endcase
                            flags_d.zero = (result_d == '0);
                        end
                    endcase
                end
            end
            S_MUL_RUN, S_DIV_RUN: begin
                step_c = 1'b1;
                busy_d = 1'b1;
                if (cnt_c == CNT_W'(1)) begin
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                flags_d = '0;
                if (func_q == ALU_MUL) begin
                    result_d = prod_c[WIDTH-1:0];
                    rem_d    = '0;
                    flags_d.overflow = mul_ovf_c;
                end else if (dz_q) begin
                    result_d = '0;
                    rem_d    = op1_q;
                    flags_d.overflow = 1'b1;
                    flags_d.div_zero = 1'b1;
                end else begin
                    result_d = quot_c;
                    rem_d    = rem_s_c;
                    flags_d.overflow = div_ovf_c;
                end
                flags_d.zero = (result_d == '0);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            func_q   <= ALU_ADD;
            op1_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            func_q   <= func_d;
            op1_q    <= op1_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            flags_q  <= flags_d;
        end
    end

    // An iterated op must reach FINISH with exactly WIDTH iterations consumed
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_FINISH) && !dz_q) begin
            assert (cnt_c == '0);
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign remainder = rem_q;
    assign overflow  = flags_q.overflow;
    assign div_zero  = flags_q.div_zero;
    assign equals    = flags_q.equals;
    assign above     = flags_q.above;
    assign zero      = flags_q.zero;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): the driver pushes the
// hand-computed response when it issues a request, the monitor pops and
// compares on every done. Latency is counted in rising edges after the
// accepting edge up to the edge that raises done.
module tb_alu_multicycle;

    localparam logic [2:0] F_ADD = 3'b000, F_SUB = 3'b001, F_MUL = 3'b010, F_DIV = 3'b011;
    localparam logic [2:0] F_AND = 3'b100, F_OR  = 3'b101, F_NOT = 3'b110, F_SLT = 3'b111;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rem;
        logic [4:0]  fl;   // {overflow, div_zero, equals, above, zero}
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  func;
    logic [31:0] op1, op2;
    logic        busy, done, overflow, div_zero, equals, above, zero;
    logic [31:0] result, remainder;

    int total = 0;
    int bad   = 0;
    exp_t  sb_q[$];
    string nm_q[$];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .func      (func),
        .op1       (op1),
        .op2       (op2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .equals    (equals),
        .above     (above),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Monitor: compare every done against the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t  e;
            exp_t  g;
            string nm;
            g = '{res: result, rem: remainder,
                  fl: {overflow, div_zero, equals, above, zero}};
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got res=%h rem=%h, want no done", result, remainder);
            end else begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                if (g !== e) begin
                    bad++;
                    $display("FAIL %s: got res=%h rem=%h fl=%b, want res=%h rem=%h fl=%b",
                             nm, g.res, g.rem, g.fl, e.res, e.rem, e.fl);
                end
            end
        end
    end

    // Issue one request, scramble operands after acceptance, and check latency/busy span
    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] erm, input logic [4:0] efl,
                         input int elat, input int ebusy, input bit poke);
        int n;
        int bc;
        sb_q.push_back('{res: er, rem: erm, fl: efl});
        nm_q.push_back(nm);
        @(negedge clk);
        start = 1'b1; func = f; op1 = a; op2 = b;
        @(posedge clk);
        #1;
        start = 1'b0; op1 = $urandom; op2 = $urandom; func = 3'($urandom);
        n = 0; bc = 0;
        while (!done && n < 100) begin
            if (busy) bc++;
            if (poke && n == 5) begin start = 1'b1; func = F_ADD; end
            if (poke && n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(elat));
        check({nm, "_busy_cycles"}, 64'(bc), 64'(ebusy));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with a pending ADD request
        rst_n = 1'b0; start = 1'b1; func = F_ADD; op1 = 32'd1; op2 = 32'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_remainder", 64'(remainder), 64'd0);
        check("reset_flags", 64'({overflow, div_zero, equals, above, zero}), 64'd0);

        // Single-cycle ops, back to back
        issue("add_ovf",  F_ADD, 32'h7FFF_FFFF, 32'h1,        32'h8000_0000, 32'h0, 5'b10000, 0, 0, 0);
        issue("sub_eq",   F_SUB, 32'd5,         32'd5,        32'h0,         32'h0, 5'b00101, 0, 0, 0);
        issue("sub_gt",   F_SUB, 32'd3,         32'hFFFF_FFFE, 32'd5,        32'h0, 5'b00010, 0, 0, 0);
        issue("sub_ovf",  F_SUB, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 32'h0, 5'b10000, 0, 0, 0);
        issue("and",      F_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 5'b00000, 0, 0, 0);
        issue("or",       F_OR,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 32'h0, 5'b00000, 0, 0, 0);
        issue("not",      F_NOT, 32'h0,         32'h1234,     32'hFFFF_FFFF, 32'h0, 5'b00000, 0, 0, 0);
        issue("slt_true", F_SLT, 32'hFFFF_FFFF, 32'd1,        32'd1,         32'h0, 5'b00000, 0, 0, 0);
        issue("slt_false",F_SLT, 32'd3,         32'hFFFF_FFFE, 32'd0,        32'h0, 5'b00001, 0, 0, 0);

        // Multiply
        issue("mul_neg",  F_MUL, 32'hFFFF_FFF9, 32'd6,        32'hFFFF_FFD6, 32'h0, 5'b00000, 33, 32, 0);
        issue("mul_ovf",  F_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,        32'h0, 5'b10001, 33, 32, 0);
        issue("mul_m1m1", F_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'h0, 5'b00000, 33, 32, 0);

        // Divide
        issue("div_neg",  F_DIV, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b00000, 33, 32, 0);
        issue("div_pos",  F_DIV, 32'd100,       32'd7,        32'd14,        32'd2,         5'b00000, 33, 32, 0);
        issue("div_negb", F_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        5'b00000, 33, 32, 0);
        issue("div_zero", F_DIV, 32'd9,         32'd0,        32'h0,         32'd9,         5'b11001, 1, 0, 0);
        issue("div_min",  F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,        5'b10000, 33, 32, 1);

        // Abort a MUL with reset on its 10th cycle; no done may follow
        @(negedge clk);
        start = 1'b1; func = F_MUL; op1 = 32'hFFFF_FFF9; op2 = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_busy_after", 64'(busy), 64'd0);
        check("abort_done_after", 64'(done), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_busy_idle", 64'(busy), 64'd0);

        issue("add_after_abort", F_ADD, 32'd2, 32'd3, 32'd5, 32'h0, 5'b00000, 0, 0, 0);

        // Result holds after done
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", 64'(result), 64'd5);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
